sync101_tx: RTL and testbench

SYNC101_TX -- requirements
Module: sync101_tx

---
 rtl/sync101_pkg.sv | 40 ++++
 rtl/sync101_tx_bit_counter.sv | 42 ++++
 rtl/sync101_tx.sv | 145 ++++++++++++++
 tb/tb_sync101_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync101_pkg.sv
// ----------------------------------------------------------------------------
// sync101_pkg
//   Shared definitions for the "101"-sync serial transmitter:
//     state_t       - transmitter FSM state (2-bit encoding)
//     SYNC_PATTERN  - the three sync bits, sent bit 2 first
//     sync_bit()    - returns one bit of SYNC_PATTERN by index
//     cnt_width()   - width of the per-state cycle counter
// ----------------------------------------------------------------------------
package sync101_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SYNC = 2'b01,
        ST_DATA = 2'b10,
        ST_GAP  = 2'b11
    } state_t;

    localparam logic [2:0] SYNC_PATTERN = 3'b101;

    // Index 2 is the first sync bit on the line, index 0 the last.
    function automatic logic sync_bit(input int idx);
        case (idx)
            0:       return SYNC_PATTERN[0];
            1:       return SYNC_PATTERN[1];
            2:       return SYNC_PATTERN[2];
            default: return 1'b0;
        endcase
    endfunction

    // Counter must hold the longest per-state length without wrapping:
    // ceil(log2(max(3, data_w, gap) + 1)).
    function automatic int cnt_width(input int data_w, input int gap);
        int m;
        m = 3;
        if (data_w > m) m = data_w;
        if (gap > m)    m = gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync101_tx_bit_counter.sv
// ----------------------------------------------------------------------------
// tx_bit_counter
//   Loadable down-counter with zero flag. Used by sync101_tx to time the
//   number of cycles spent in each FSM state.
//   Ports:
//     clk       in   clock
//     rst       in   asynchronous active-high reset (clears count)
//     load      in   load load_val this cycle (has priority over dec)
//     load_val  in   W  value to load
//     dec       in   decrement by one; saturates at zero
//     cnt       out  W  current count
//     zero      out  count equals zero
// ----------------------------------------------------------------------------
module tx_bit_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            // Saturate rather than wrap; the FSM always reloads before
            // it would need to go below zero.
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sync101_tx.sv
// ----------------------------------------------------------------------------
// sync101_tx
//   Frame serializer. Each accepted word is sent as:
//     "101" sync (3 cycles), payload MSB-first (DATA_W cycles),
//     GAP idle zeros, then back to IDLE.
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   asynchronous active-high reset
//     tx_data     in   DATA_W  payload word, sampled on handshake only
//     tx_valid    in   source has a word
//     tx_ready    out  word can be accepted this cycle (IDLE only)
//     dout        out  serial line, registered
//     busy        out  frame in progress (SYNC, DATA or GAP)
//     frame_done  out  one-cycle pulse on the final GAP cycle
// ----------------------------------------------------------------------------
module sync101_tx
    import sync101_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = cnt_width(DATA_W, GAP);

    // Counter reload values: a state lasting N cycles is entered with N-1
    // and left on the cycle where the counter reads zero.
    localparam logic [CNT_W-1:0] LOAD_SYNC = CNT_W'(2);
    localparam logic [CNT_W-1:0] LOAD_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LOAD_GAP  = CNT_W'(GAP - 1);

    state_t            state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic              dout_next;
    logic              accept;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_zero;

    tx_bit_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // tx_ready is gated by rst so it reads 0 throughout reset and rises
    // as soon as reset is released.
    assign tx_ready   = (state == ST_IDLE) && !rst;
    assign accept     = tx_valid && tx_ready;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_GAP) && cnt_zero;

    // Next-state logic also computes the value dout will carry in the next
    // cycle, so the line itself comes straight from a flop.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_next   = state;
        shreg_next   = shreg;
        dout_next    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next   = ST_SYNC;
                    shreg_next   = tx_data;
                    cnt_load     = 1'b1;
                    cnt_load_val = LOAD_SYNC;
                    dout_next    = sync_bit(2);
                end
            end

            ST_SYNC: begin
                if (cnt_zero) begin
                    state_next   = ST_DATA;
                    cnt_load     = 1'b1;
                    cnt_load_val = LOAD_DATA;
                    dout_next    = shreg[DATA_W-1];
                    shreg_next   = shreg << 1;
                end else begin
                    dout_next    = sync_bit(int'(cnt) - 1);
                end
            end

            ST_DATA: begin
                if (cnt_zero) begin
                    state_next   = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = LOAD_GAP;
                end else begin
                    // Payload MSB always sits at the top; shifting left
                    // presents the next bit. No stuffing is applied.
                    dout_next    = shreg[DATA_W-1];
                    shreg_next   = shreg << 1;
                end
            end

            ST_GAP: begin
                if (cnt_zero) begin
                    state_next   = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The counter runs down in every non-IDLE cycle except the one where
    // it is being reloaded for the next state.
    assign cnt_dec = (state != ST_IDLE) && !cnt_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            dout  <= 1'b0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            dout  <= dout_next;
        end
    end

endmodule

// File: tb/tb_sync101_tx.sv
// ----------------------------------------------------------------------------
// tb_sync101_tx
//   Self-checking bench for sync101_tx. A negedge monitor pops expected
//   line bits from a scoreboard queue filled when each word is offered.
//   A second instance covers the DATA_W=1 / GAP=1 corner.
// ----------------------------------------------------------------------------
module tb_sync101_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       dout;
    logic       busy;
    logic       frame_done;

    logic [0:0] c_data;
    logic       c_valid;
    logic       c_ready;
    logic       c_dout;
    logic       c_busy;
    logic       c_done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic dout;
        logic done;
    } exp_t;

    exp_t sb_q[$];

    sync101_tx #(.DATA_W(8), .GAP(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    sync101_tx #(.DATA_W(1), .GAP(1)) dut_c (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (c_data),
        .tx_valid   (c_valid),
        .tx_ready   (c_ready),
        .dout       (c_dout),
        .busy       (c_busy),
        .frame_done (c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Moore, non-overlapping "101" detector fed from dout.
    typedef enum logic [1:0] {D_S0, D_S1, D_S10, D_S101} det_t;
    det_t det_state;
    logic det_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_state <= D_S0;
        end else begin
            case (det_state)
                D_S0:    det_state <= dout ? D_S1   : D_S0;
                D_S1:    det_state <= dout ? D_S1   : D_S10;
                D_S10:   det_state <= dout ? D_S101 : D_S0;
                default: det_state <= dout ? D_S1   : D_S0;
            endcase
        end
    end
    assign det_y = (det_state == D_S101);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line contents for one DATA_W=8, GAP=2 frame.
    task automatic push_frame(input logic [7:0] d);
        exp_t e;
        e.done = 1'b0;
        e.dout = 1'b1; sb_q.push_back(e);
        e.dout = 1'b0; sb_q.push_back(e);
        e.dout = 1'b1; sb_q.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            e.dout = d[i];
            sb_q.push_back(e);
        end
        e.dout = 1'b0; sb_q.push_back(e);
        e.done = 1'b1; sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the accepting edge; returns edges elapsed. Leaves time in c1.
    task automatic wait_accept(output int cycles);
        logic acc;
        cycles = 0;
        forever begin
            acc = tx_ready && tx_valid;
            tick();
            cycles++;
            if (acc) break;
            if (cycles > 100) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: frame cycles are scored against the queue; idle cycles
    // must show a quiet line and a ready block.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_busy", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("dout", {31'd0, dout}, {31'd0, e.dout});
                    check("frame_done", {31'd0, frame_done}, {31'd0, e.done});
                end
            end else begin
                check("idle_dout", {31'd0, dout}, 32'd0);
                check("idle_done", {31'd0, frame_done}, 32'd0);
                check("idle_ready", {31'd0, tx_ready}, 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int y_cnt;
        int y_pos;
        bit c_exp_dout[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bit c_exp_done[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bit c_exp_busy[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        c_data   = 1'b0;
        c_valid  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_dout",  {31'd0, dout}, 32'd0);
        check("rst_done",  {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, tx_ready}, 32'd1);
        repeat (2) tick();

        // Single frame 8'hA5
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        push_frame(8'hA5);
        wait_accept(n);
        tx_valid = 1'b0;
        check("a5_busy_c1", {31'd0, busy}, 32'd1);
        check("a5_dout_c1", {31'd0, dout}, 32'd1);
        repeat (12) tick();
        check("a5_done_c13", {31'd0, frame_done}, 32'd1);
        check("a5_busy_c13", {31'd0, busy}, 32'd1);
        tick();
        check("a5_ready_c14", {31'd0, tx_ready}, 32'd1);
        check("a5_busy_c14", {31'd0, busy}, 32'd0);
        check("a5_queue", sb_q.size(), 32'd0);
        repeat (2) tick();

        // Input change and tx_valid pulse during c5 are ignored
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        push_frame(8'hA5);
        wait_accept(n);
        tx_valid = 1'b0;
        repeat (4) tick();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        wait_idle();
        repeat (5) tick();
        check("ign_no_extra", {31'd0, busy}, 32'd0);
        check("ign_queue", sb_q.size(), 32'd0);

        // Back-to-back 8'hFF then 8'h00 with tx_valid held
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        push_frame(8'hFF);
        wait_accept(n);
        tx_data = 8'h00;
        push_frame(8'h00);
        wait_accept(n);
        tx_valid = 1'b0;
        check("b2b_accept_edge", n, 32'd14);
        wait_idle();
        check("b2b_queue", sb_q.size(), 32'd0);
        repeat (2) tick();

        // Loopback into the "101" detector while sending 8'h00
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        push_frame(8'h00);
        wait_accept(n);
        tx_valid = 1'b0;
        y_cnt = 0;
        y_pos = 0;
        for (int k = 1; k <= 16; k++) begin
            if (det_y) begin
                y_cnt++;
                y_pos = k;
            end
            tick();
        end
        check("loop_y_count", y_cnt, 32'd1);
        check("loop_y_cycle", y_pos, 32'd4);
        check("loop_queue", sb_q.size(), 32'd0);

        // Reset in c6 aborts the frame
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        push_frame(8'hA5);
        wait_accept(n);
        tx_valid = 1'b0;
        repeat (5) tick();
        check("abort_busy_c6", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_dout", {31'd0, dout}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, frame_done}, 32'd0);
        check("abort_ready", {31'd0, tx_ready}, 32'd0);
        sb_q.delete();
        for (int k = 0; k < 2; k++) begin
            tick();
            check("abort_hold_done", {31'd0, frame_done}, 32'd0);
            check("abort_hold_busy", {31'd0, busy}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("abort_ready_release", {31'd0, tx_ready}, 32'd1);
        repeat (16) tick();
        check("abort_no_resume", {31'd0, busy}, 32'd0);

        // DATA_W=1, GAP=1 corner: 1'b1 -> 1,0,1,1,0 then IDLE
        check("corner_ready", {31'd0, c_ready}, 32'd1);
        c_data  = 1'b1;
        c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        c_data  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("corner_dout_c%0d", k + 1), {31'd0, c_dout}, {31'd0, c_exp_dout[k]});
            check($sformatf("corner_done_c%0d", k + 1), {31'd0, c_done}, {31'd0, c_exp_done[k]});
            check($sformatf("corner_busy_c%0d", k + 1), {31'd0, c_busy}, {31'd0, c_exp_busy[k]});
            tick();
        end
        check("corner_ready_end", {31'd0, c_ready}, 32'd1);

        check("final_queue", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
